regfile_rename: RTL and testbench

- Parametrised architectural register file with register-status (rename) table for the Tomasulo/ROB core.
- Sits between decode/issue and the ROB.
- Provides NUM_READ registered operand read ports returning value, busy flag and producing ROB tag.
- Accepts one rename (issue) and one commit per cycle, plus a global flush for misprediction rollback.

---
 rtl/regfile_rename.sv | 134 +++++++++++++
 tb/tb_regfile_rename.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - architectural register file with rename (register-status) table
// Optional busy counter output enabled by defining REGFILE_BUSY_CNT_EN.
module regfile_rename #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int ROB_IDX_WIDTH  = 4,
   parameter int NUM_READ       = 2
) (
   input  logic                               clk_in,
   input  logic                               rst_in,
   input  logic                               rdy_in,
   input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
   output logic [NUM_READ-1:0]                rd_busy,
   output logic [NUM_READ*ROB_IDX_WIDTH-1:0]  rd_tag,
   input  logic                               issue_en,
   input  logic [REG_ADDR_WIDTH-1:0]          issue_rd,
   input  logic [ROB_IDX_WIDTH-1:0]           issue_tag,
   input  logic                               commit_en,
   input  logic [REG_ADDR_WIDTH-1:0]          commit_rd,
   input  logic [ROB_IDX_WIDTH-1:0]           commit_tag,
   input  logic [DATA_WIDTH-1:0]              commit_data,
   input  logic                               flush_in
`ifdef REGFILE_BUSY_CNT_EN
   ,
   output logic [REG_ADDR_WIDTH:0]            busy_cnt
`endif
);

   localparam int NREG = 2**REG_ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]    value_q [NREG];
   logic [ROB_IDX_WIDTH-1:0] tag_q   [NREG];
   logic [ROB_IDX_WIDTH-1:0] tag_d   [NREG];
   logic [NREG-1:0]          busy_q;
   logic [NREG-1:0]          busy_d;

   logic [NUM_READ*DATA_WIDTH-1:0]    rd_data_d;
   logic [NUM_READ-1:0]               rd_busy_d;
   logic [NUM_READ*ROB_IDX_WIDTH-1:0] rd_tag_d;

   // x0 is hard-wired: commits and issues targeting it are discarded here.
   logic commit_ok;
   logic issue_ok;
   logic commit_clr;

   assign commit_ok  = commit_en && (commit_rd != '0);
   assign issue_ok   = issue_en && (issue_rd != '0) && !flush_in;
   assign commit_clr = commit_ok && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);

   // Next rename state: flush clears everything, otherwise commit clears then issue wins.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) tag_d[i] = tag_q[i];
      if (flush_in) begin
         busy_d = '0;
         for (int i = 0; i < NREG; i++) tag_d[i] = '0;
      end else begin
         if (commit_clr) busy_d[commit_rd] = 1'b0;
         if (issue_ok) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_tag;
         end
      end
   end

   // Read ports see pre-issue state with commit bypass; a flush hides busy/tag.
   always_comb begin
      rd_data_d = '0;
      rd_busy_d = '0;
      rd_tag_d  = '0;
      for (int k = 0; k < NUM_READ; k++) begin
         if (rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0) begin
            if (commit_ok && (commit_rd == rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
               rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = commit_data;
               rd_busy_d[k] = busy_q[commit_rd] && (tag_q[commit_rd] != commit_tag);
            end else begin
               rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] =
                  value_q[rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
               rd_busy_d[k] = busy_q[rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
            end
            rd_tag_d[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] =
               tag_q[rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
            if (flush_in) begin
               rd_busy_d[k] = 1'b0;
               rd_tag_d[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = '0;
            end
         end
      end
   end

   // Register values: only commits write, and they still land during a flush.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NREG; i++) value_q[i] <= '0;
      end else if (rdy_in && commit_ok) begin
         value_q[commit_rd] <= commit_data;
      end
   end

   // Rename table and read-port output registers, held while stalled.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy_q  <= '0;
         for (int i = 0; i < NREG; i++) tag_q[i] <= '0;
         rd_data <= '0;
         rd_busy <= '0;
         rd_tag  <= '0;
      end else if (rdy_in) begin
         busy_q  <= busy_d;
         for (int i = 0; i < NREG; i++) tag_q[i] <= tag_d[i];
         rd_data <= rd_data_d;
         rd_busy <= rd_busy_d;
         rd_tag  <= rd_tag_d;
      end
   end

`ifdef REGFILE_BUSY_CNT_EN
   logic [REG_ADDR_WIDTH:0] cnt_d;

   // Population count of the next busy vector keeps the counter exact in every case.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < NREG; i++) cnt_d = cnt_d + (REG_ADDR_WIDTH+1)'(busy_d[i]);
   end

   // Busy counter register, updated alongside the rename table.
   always_ff @(posedge clk_in) begin
      if (rst_in)      busy_cnt <= '0;
      else if (rdy_in) busy_cnt <= cnt_d;
   end
`endif

endmodule

// File: tb/tb_regfile_rename.sv
// tb/tb_regfile_rename.sv - directed self-checking bench for regfile_rename
module tb_regfile_rename;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [7:0]  rd_tag;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [3:0]  issue_tag;
   logic        commit_en;
   logic [4:0]  commit_rd;
   logic [3:0]  commit_tag;
   logic [31:0] commit_data;
   logic        flush_in;
`ifdef REGFILE_BUSY_CNT_EN
   logic [5:0]  busy_cnt;
`endif

   int checks = 0;
   int errors = 0;

   regfile_rename dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
      .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
      .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_data(commit_data), .flush_in(flush_in)
`ifdef REGFILE_BUSY_CNT_EN
      , .busy_cnt(busy_cnt)
`endif
   );

   always #5 clk_in = ~clk_in;

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      issue_en = 0; issue_rd = 0; issue_tag = 0;
      commit_en = 0; commit_rd = 0; commit_tag = 0; commit_data = 0;
      flush_in = 0; rdy_in = 1;
   endtask

   task automatic test_reset();
      idle(); rst_in = 1; rd_addr = {5'd0, 5'd5};
      cyc(); cyc();
      checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", rd_data); end
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", rd_busy); end
      checks++; if (rd_tag !== 8'h0) begin errors++; $display("FAIL reset_tag got %h want 0", rd_tag); end
      rst_in = 0; cyc();
`ifdef REGFILE_BUSY_CNT_EN
      checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", busy_cnt); end
`endif
   endtask

   task automatic test_issue_commit();
      idle(); issue_en = 1; issue_rd = 3; issue_tag = 7; rd_addr = {5'd3, 5'd3};
      cyc();
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL ic_preissue_busy got %b want 00", rd_busy); end
      idle(); cyc();
      checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL ic_busy got %b want 11", rd_busy); end
      checks++; if (rd_tag !== 8'h77) begin errors++; $display("FAIL ic_tag got %h want 77", rd_tag); end
      commit_en = 1; commit_rd = 3; commit_tag = 7; commit_data = 32'hDEADBEEF;
      cyc();
      checks++; if (rd_data !== 64'hDEADBEEF_DEADBEEF) begin errors++; $display("FAIL ic_bypass_data got %h want deadbeefdeadbeef", rd_data); end
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL ic_bypass_busy got %b want 00", rd_busy); end
      idle(); cyc();
      checks++; if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin errors++; $display("FAIL ic_after got %h/%b want deadbeef/0", rd_data[31:0], rd_busy[0]); end
   endtask

   task automatic test_rename_conflict();
      idle(); rd_addr = {5'd0, 5'd4};
      issue_en = 1; issue_rd = 4; issue_tag = 2; cyc();
      issue_tag = 5; cyc();
      idle(); commit_en = 1; commit_rd = 4; commit_tag = 2; commit_data = 32'h11;
      cyc();
      checks++; if (rd_data[31:0] !== 32'h11 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd5) begin errors++; $display("FAIL rc_bypass got %h/%b/%h want 11/1/5", rd_data[31:0], rd_busy[0], rd_tag[3:0]); end
      idle(); cyc();
      checks++; if (rd_data[31:0] !== 32'h11 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd5) begin errors++; $display("FAIL rc_read got %h/%b/%h want 11/1/5", rd_data[31:0], rd_busy[0], rd_tag[3:0]); end
      commit_en = 1; commit_rd = 4; commit_tag = 5; commit_data = 32'h22; cyc();
      idle(); cyc();
      checks++; if (rd_data[31:0] !== 32'h22 || rd_busy[0] !== 1'b0) begin errors++; $display("FAIL rc_final got %h/%b want 22/0", rd_data[31:0], rd_busy[0]); end
   endtask

   task automatic test_same_cycle_issue();
      idle(); rd_addr = {5'd6, 5'd6}; issue_en = 1; issue_rd = 6; issue_tag = 9;
      cyc();
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL sc_same got %b want 00", rd_busy); end
      idle(); cyc();
      checks++; if (rd_busy !== 2'b11 || rd_tag !== 8'h99) begin errors++; $display("FAIL sc_next got %b/%h want 11/99", rd_busy, rd_tag); end
   endtask

   task automatic test_issue_commit_same();
      idle(); rd_addr = {5'd0, 5'd10};
      issue_en = 1; issue_rd = 10; issue_tag = 3; cyc();
      issue_tag = 8; commit_en = 1; commit_rd = 10; commit_tag = 3; commit_data = 32'hAB; cyc();
      idle(); cyc();
      checks++; if (rd_data[31:0] !== 32'hAB || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd8) begin errors++; $display("FAIL icsame got %h/%b/%h want ab/1/8", rd_data[31:0], rd_busy[0], rd_tag[3:0]); end
      // leave x10 idle again for later counts
      commit_en = 1; commit_rd = 10; commit_tag = 8; commit_data = 32'hAB; cyc();
      idle();
   endtask

   task automatic test_x0();
      idle(); rd_addr = {5'd0, 5'd0};
      issue_en = 1; issue_rd = 0; issue_tag = 1;
      commit_en = 1; commit_rd = 0; commit_tag = 1; commit_data = 32'hFFFFFFFF;
      cyc();
      checks++; if (rd_data !== 64'h0 || rd_busy !== 2'b00 || rd_tag !== 8'h0) begin errors++; $display("FAIL x0_bypass got %h/%b/%h want 0/0/0", rd_data, rd_busy, rd_tag); end
      idle(); cyc();
      checks++; if (rd_data !== 64'h0 || rd_busy !== 2'b00 || rd_tag !== 8'h0) begin errors++; $display("FAIL x0_read got %h/%b/%h want 0/0/0", rd_data, rd_busy, rd_tag); end
`ifdef REGFILE_BUSY_CNT_EN
      checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL x0_cnt got %0d want 1", busy_cnt); end
`endif
   endtask

   task automatic test_flush();
      idle(); rd_addr = {5'd2, 5'd1};
      issue_en = 1; issue_rd = 1; issue_tag = 1; cyc();
      issue_rd = 2; issue_tag = 2; cyc();
      issue_rd = 7; issue_tag = 3; cyc();
      idle(); cyc();
`ifdef REGFILE_BUSY_CNT_EN
      checks++; if (busy_cnt !== 6'd4) begin errors++; $display("FAIL fl_cnt_pre got %0d want 4", busy_cnt); end
`endif
      checks++; if (rd_busy !== 2'b11 || rd_tag !== 8'h21) begin errors++; $display("FAIL fl_pre got %b/%h want 11/21", rd_busy, rd_tag); end
      flush_in = 1; commit_en = 1; commit_rd = 1; commit_tag = 4; commit_data = 32'h55;
      issue_en = 1; issue_rd = 5; issue_tag = 4;
      cyc();
      checks++; if (rd_data[31:0] !== 32'h55 || rd_busy !== 2'b00 || rd_tag !== 8'h0) begin errors++; $display("FAIL fl_cycle got %h/%b/%h want 55/00/00", rd_data[31:0], rd_busy, rd_tag); end
      idle(); rd_addr = {5'd7, 5'd1}; cyc();
      checks++; if (rd_data[31:0] !== 32'h55 || rd_busy !== 2'b00) begin errors++; $display("FAIL fl_x1x7 got %h/%b want 55/00", rd_data[31:0], rd_busy); end
      rd_addr = {5'd5, 5'd2}; cyc();
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL fl_x2x5 got %b want 00", rd_busy); end
`ifdef REGFILE_BUSY_CNT_EN
      checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL fl_cnt got %0d want 0", busy_cnt); end
`endif
   endtask

   task automatic test_stall();
      idle(); rd_addr = {5'd1, 5'd1}; cyc();
      rdy_in = 0; rd_addr = {5'd3, 5'd3};
      issue_en = 1; issue_rd = 8; issue_tag = 6;
      commit_en = 1; commit_rd = 9; commit_tag = 0; commit_data = 32'h77;
      cyc();
      checks++; if (rd_data !== 64'h00000055_00000055 || rd_busy !== 2'b00) begin errors++; $display("FAIL st_hold got %h/%b want 0000005500000055/00", rd_data, rd_busy); end
      idle(); rd_addr = {5'd9, 5'd8}; cyc();
      checks++; if (rd_busy !== 2'b00 || rd_data !== 64'h0) begin errors++; $display("FAIL st_after got %h/%b want 0/00", rd_data, rd_busy); end
`ifdef REGFILE_BUSY_CNT_EN
      checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL st_cnt got %0d want 0", busy_cnt); end
`endif
   endtask

   initial begin
      rst_in = 1; rd_addr = '0;
      idle();
      test_reset();
      test_issue_commit();
      test_rename_conflict();
      test_same_cycle_issue();
      test_issue_commit_same();
      test_x0();
      test_flush();
      test_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
